// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, major opcodes
// and the select codes the datapath expects on its mux and ALU control inputs.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_LUI,
    ALU_WB,
    ADDR,
    MEM_RD,
    LOAD_WB,
    MEM_WR,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Dispatch from DECODE; anything outside the supported subset traps.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:          nxt = EXEC_R;
      OP_IALU:           nxt = EXEC_I;
      OP_LOAD, OP_STORE: nxt = ADDR;
      OP_BRANCH:         nxt = BRANCH;
      OP_LUI:            nxt = EXEC_LUI;
      default:           nxt = TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences the 64-bit datapath strobes from the IR
// opcode/funct3 and ALU zero flag, with memory ready handshakes and a watchdog.
module control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 0,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       LoadAOut,
  output logic       RegWrite,
  output logic       LoadRegA,
  output logic       LoadRegB,
  output logic       MemToReg,
  output logic       DMemRead,
  output logic       DMemWrite,
  output logic       LoadMDR,
  output logic       IMemRead,
  output logic       IRWrite,
  output logic       retire,
  output logic       trap
);

  localparam logic [WAIT_W-1:0] WaitLimit  = WAIT_W'(WAIT_MAX);
  localparam bit                WatchdogOn = (WAIT_MAX != 0);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_ready;
  logic              in_wait;
  logic              timeout;
  logic              br_legal;
  logic              br_taken;

  always_comb begin
    mem_ready = (state_q == FETCH) ? imem_ready : dmem_ready;
    in_wait   = is_wait_state(state_q);
    timeout   = WatchdogOn && in_wait && !mem_ready && (wait_q == WaitLimit);
    br_legal  = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    br_taken  = (funct3 == F3_BEQ) ? zero : ((funct3 == F3_BNE) ? !zero : 1'b0);
  end

  // A ready arriving on the limit cycle is checked first, so it beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_ready)   state_d = DECODE;
        else if (timeout) state_d = TRAP;
      end
      DECODE:                   state_d = decode_next(opcode);
      EXEC_R, EXEC_I, EXEC_LUI: state_d = ALU_WB;
      ALU_WB, LOAD_WB:          state_d = FETCH;
      ADDR:                     state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (dmem_ready)   state_d = LOAD_WB;
        else if (timeout) state_d = TRAP;
      end
      MEM_WR: begin
        if (dmem_ready)   state_d = FETCH;
        else if (timeout) state_d = TRAP;
      end
      BRANCH:                   state_d = br_legal ? FETCH : TRAP;
      TRAP:                     state_d = TRAP;
      default:                  state_d = FETCH;
    endcase

    wait_d = '0;
    if (WatchdogOn && in_wait && !mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Reset forces every strobe low in the same cycle so an aborted instruction leaves no side effects.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 1'b0;
    DMemRead    = 1'b0;
    DMemWrite   = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    retire      = 1'b0;
    trap        = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          IMemRead = 1'b1;
          ALUSrcB  = SRCB_FOUR;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = SRCB_BIMM;
          LoadAOut = 1'b1;
        end
        EXEC_R: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALUOP_FUNCT;
          LoadAOut = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_IMM;
          ALUOp    = ALUOP_FUNCT;
          LoadAOut = 1'b1;
        end
        EXEC_LUI: begin
          ALUSrcB  = SRCB_IMM;
          ALUOp    = ALUOP_PASSB;
          LoadAOut = 1'b1;
        end
        ALU_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        ADDR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_IMM;
          LoadAOut = 1'b1;
        end
        MEM_RD: begin
          DMemRead = 1'b1;
          LoadMDR  = dmem_ready;
        end
        LOAD_WB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          retire   = 1'b1;
        end
        MEM_WR: begin
          DMemWrite = 1'b1;
          retire    = dmem_ready;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          PCWrite     = br_legal && br_taken;
          retire      = br_legal;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: two instances (watchdog off / WAIT_MAX=5)
// driven in lockstep and compared per cycle against an instruction-level model.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;

  logic       pcWrite0, pcWriteCond0, aluSrcA0, loadAOut0, regWrite0, loadRegA0, loadRegB0;
  logic       memToReg0, dMemRead0, dMemWrite0, loadMDR0, iMemRead0, irWrite0, retire0, trap0;
  logic [1:0] pcSource0, aluSrcB0, aluOp0;
  logic       pcWriteW, pcWriteCondW, aluSrcAW, loadAOutW, regWriteW, loadRegAW, loadRegBW;
  logic       memToRegW, dMemReadW, dMemWriteW, loadMDRW, iMemReadW, irWriteW, retireW, trapW;
  logic [1:0] pcSourceW, aluSrcBW, aluOpW;

  logic [20:0] obs0, obsW;

  int   checks = 0;
  int   errors = 0;
  int   cycCount;
  int   retCycle;
  logic lastRetire;

  // Output vector layout: PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp, then single strobes.
  localparam logic [20:0] B_PCW  = 21'd1 << 20;
  localparam logic [20:0] B_PCWC = 21'd1 << 19;
  localparam logic [20:0] B_SRCA = 21'd1 << 16;
  localparam logic [20:0] B_LAO  = 21'd1 << 11;
  localparam logic [20:0] B_RW   = 21'd1 << 10;
  localparam logic [20:0] B_LRA  = 21'd1 << 9;
  localparam logic [20:0] B_LRB  = 21'd1 << 8;
  localparam logic [20:0] B_M2R  = 21'd1 << 7;
  localparam logic [20:0] B_DR   = 21'd1 << 6;
  localparam logic [20:0] B_DW   = 21'd1 << 5;
  localparam logic [20:0] B_MDR  = 21'd1 << 4;
  localparam logic [20:0] B_IMR  = 21'd1 << 3;
  localparam logic [20:0] B_IRW  = 21'd1 << 2;
  localparam logic [20:0] B_RET  = 21'd1 << 1;
  localparam logic [20:0] B_TRAP = 21'd1;

  localparam logic [20:0] V_NONE       = 21'd0;
  localparam logic [20:0] V_FETCH_WAIT = B_IMR | (21'd1 << 14);
  localparam logic [20:0] V_FETCH_GO   = V_FETCH_WAIT | B_IRW | B_PCW;
  localparam logic [20:0] V_DECODE     = B_LRA | B_LRB | (21'd3 << 14) | B_LAO;
  localparam logic [20:0] V_EXEC_R     = B_SRCA | (21'd0 << 14) | (21'd2 << 12) | B_LAO;
  localparam logic [20:0] V_EXEC_I     = B_SRCA | (21'd2 << 14) | (21'd2 << 12) | B_LAO;
  localparam logic [20:0] V_EXEC_LUI   = (21'd2 << 14) | (21'd3 << 12) | B_LAO;
  localparam logic [20:0] V_ALU_WB     = B_RW | B_RET;
  localparam logic [20:0] V_ADDR       = B_SRCA | (21'd2 << 14) | B_LAO;
  localparam logic [20:0] V_RD_WAIT    = B_DR;
  localparam logic [20:0] V_RD_GO      = B_DR | B_MDR;
  localparam logic [20:0] V_LOAD_WB    = B_RW | B_M2R | B_RET;
  localparam logic [20:0] V_WR_WAIT    = B_DW;
  localparam logic [20:0] V_WR_GO      = B_DW | B_RET;
  localparam logic [20:0] V_BR_BASE    = B_SRCA | (21'd1 << 12) | B_PCWC | (21'd1 << 17);
  localparam logic [20:0] V_TRAP       = B_TRAP;

  control_fsm #(.WAIT_MAX(0), .WAIT_W(8)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(pcWrite0), .PCWriteCond(pcWriteCond0), .PCSource(pcSource0),
    .ALUSrcA(aluSrcA0), .ALUSrcB(aluSrcB0), .ALUOp(aluOp0), .LoadAOut(loadAOut0),
    .RegWrite(regWrite0), .LoadRegA(loadRegA0), .LoadRegB(loadRegB0), .MemToReg(memToReg0),
    .DMemRead(dMemRead0), .DMemWrite(dMemWrite0), .LoadMDR(loadMDR0), .IMemRead(iMemRead0),
    .IRWrite(irWrite0), .retire(retire0), .trap(trap0)
  );

  control_fsm #(.WAIT_MAX(5), .WAIT_W(8)) dutW (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(pcWriteW), .PCWriteCond(pcWriteCondW), .PCSource(pcSourceW),
    .ALUSrcA(aluSrcAW), .ALUSrcB(aluSrcBW), .ALUOp(aluOpW), .LoadAOut(loadAOutW),
    .RegWrite(regWriteW), .LoadRegA(loadRegAW), .LoadRegB(loadRegBW), .MemToReg(memToRegW),
    .DMemRead(dMemReadW), .DMemWrite(dMemWriteW), .LoadMDR(loadMDRW), .IMemRead(iMemReadW),
    .IRWrite(irWriteW), .retire(retireW), .trap(trapW)
  );

  assign obs0 = {pcWrite0, pcWriteCond0, pcSource0, aluSrcA0, aluSrcB0, aluOp0, loadAOut0,
                 regWrite0, loadRegA0, loadRegB0, memToReg0, dMemRead0, dMemWrite0,
                 loadMDR0, iMemRead0, irWrite0, retire0, trap0};
  assign obsW = {pcWriteW, pcWriteCondW, pcSourceW, aluSrcAW, aluSrcBW, aluOpW, loadAOutW,
                 regWriteW, loadRegAW, loadRegBW, memToRegW, dMemReadW, dMemWriteW,
                 loadMDRW, iMemReadW, irWriteW, retireW, trapW};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=no_finish expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic applyStimulus(input logic im, input logic dm, input logic z);
    imem_ready = im;
    dmem_ready = dm;
    zero       = z;
  endtask

  // Entered just after a rising edge; samples mid-cycle and returns just after the next rising edge.
  task automatic checkOutput(input string tag, input logic [20:0] e0, input logic [20:0] eW);
    @(negedge clk);
    checks++;
    assert (obs0 === e0) else begin
      errors++;
      $error("[TB] FAIL %s dut0 observed=%h expected=%h", tag, obs0, e0);
    end
    checks++;
    assert (obsW === eW) else begin
      errors++;
      $error("[TB] FAIL %s dutW observed=%h expected=%h", tag, obsW, eW);
    end
    lastRetire = obs0[1];
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag, input logic im, input logic dm, input logic z,
                       input logic [20:0] e);
    applyStimulus(im, dm, z);
    checkOutput(tag, e, e);
    cycCount++;
    if (lastRetire && retCycle < 0) retCycle = cycCount;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_hold", V_NONE, V_NONE);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_hold", V_NONE, V_NONE);
    reset = 1'b0;
  endtask

  // Instruction-level model: expected strobe sequence and latency from the instruction class.
  task automatic runInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic z, input int fw, input int mw);
    int expLat;
    logic taken;
    opcode   = op;
    funct3   = f3;
    cycCount = 0;
    retCycle = -1;
    for (int i = 0; i < fw; i++) cycle({tag, "_fetch_wait"}, 1'b0, 1'($urandom), z, V_FETCH_WAIT);
    cycle({tag, "_fetch"}, 1'b1, 1'($urandom), z, V_FETCH_GO);
    cycle({tag, "_decode"}, 1'($urandom), 1'($urandom), z, V_DECODE);
    case (op)
      7'b0110011: begin
        cycle({tag, "_exec_r"}, 1'($urandom), 1'($urandom), z, V_EXEC_R);
        cycle({tag, "_wb"}, 1'($urandom), 1'($urandom), z, V_ALU_WB);
        expLat = 4 + fw;
      end
      7'b0010011: begin
        cycle({tag, "_exec_i"}, 1'($urandom), 1'($urandom), z, V_EXEC_I);
        cycle({tag, "_wb"}, 1'($urandom), 1'($urandom), z, V_ALU_WB);
        expLat = 4 + fw;
      end
      7'b0110111: begin
        cycle({tag, "_exec_lui"}, 1'($urandom), 1'($urandom), z, V_EXEC_LUI);
        cycle({tag, "_wb"}, 1'($urandom), 1'($urandom), z, V_ALU_WB);
        expLat = 4 + fw;
      end
      7'b0000011: begin
        cycle({tag, "_addr"}, 1'($urandom), 1'($urandom), z, V_ADDR);
        for (int i = 0; i < mw; i++) cycle({tag, "_rd_wait"}, 1'($urandom), 1'b0, z, V_RD_WAIT);
        cycle({tag, "_rd"}, 1'($urandom), 1'b1, z, V_RD_GO);
        cycle({tag, "_load_wb"}, 1'($urandom), 1'($urandom), z, V_LOAD_WB);
        expLat = 5 + fw + mw;
      end
      7'b0100011: begin
        cycle({tag, "_addr"}, 1'($urandom), 1'($urandom), z, V_ADDR);
        for (int i = 0; i < mw; i++) cycle({tag, "_wr_wait"}, 1'($urandom), 1'b0, z, V_WR_WAIT);
        cycle({tag, "_wr"}, 1'($urandom), 1'b1, z, V_WR_GO);
        expLat = 4 + fw + mw;
      end
      default: begin
        taken = (f3 == 3'b000) ? z : !z;
        cycle({tag, "_branch"}, 1'($urandom), 1'($urandom), z,
              V_BR_BASE | B_RET | (taken ? B_PCW : V_NONE));
        expLat = 3 + fw;
      end
    endcase
    checks++;
    assert (retCycle === expLat) else begin
      errors++;
      $error("[TB] FAIL %s_latency observed=%0d expected=%0d", tag, retCycle, expLat);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int kind;
    reset      = 1'b1;
    opcode     = 7'd0;
    funct3     = 3'd0;
    zero       = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    lastRetire = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    runInstr("r_add", 7'b0110011, 3'b000, 1'b0, 0, 0);
    runInstr("load_stall3", 7'b0000011, 3'b011, 1'b0, 0, 3);
    runInstr("beq_taken", 7'b1100011, 3'b000, 1'b1, 0, 0);
    runInstr("bne_not_taken", 7'b1100011, 3'b001, 1'b1, 0, 0);
    runInstr("store", 7'b0100011, 3'b011, 1'b0, 1, 2);
    runInstr("lui", 7'b0110111, 3'b101, 1'b1, 2, 0);

    opcode = 7'b1101111;
    funct3 = 3'b000;
    cycle("jal_fetch", 1'b1, 1'b0, 1'b0, V_FETCH_GO);
    cycle("jal_decode", 1'b0, 1'b0, 1'b0, V_DECODE);
    for (int i = 0; i < 20; i++) cycle("jal_trap", 1'($urandom), 1'($urandom), 1'($urandom), V_TRAP);
    doReset();
    cycle("jal_after_reset", 1'b0, 1'b0, 1'b0, V_FETCH_WAIT);

    runInstr("i_after_trap", 7'b0010011, 3'b111, 1'b0, 0, 0);

    opcode = 7'b1100011;
    funct3 = 3'b010;
    cycle("badbr_fetch", 1'b1, 1'b0, 1'b0, V_FETCH_GO);
    cycle("badbr_decode", 1'b0, 1'b0, 1'b1, V_DECODE);
    cycle("badbr_branch", 1'b1, 1'b1, 1'b1, V_BR_BASE);
    cycle("badbr_trap", 1'b1, 1'b1, 1'b0, V_TRAP);
    cycle("badbr_trap", 1'b1, 1'b1, 1'b1, V_TRAP);
    doReset();

    opcode = 7'b0110011;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'b0);
      checkOutput("wd_waiting", V_FETCH_WAIT, V_FETCH_WAIT);
    end
    for (int i = 7; i <= 10; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'b0);
      checkOutput("wd_expired", V_FETCH_WAIT, V_TRAP);
    end
    doReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("wd_near_limit", V_FETCH_WAIT, V_FETCH_WAIT);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wd_ready_on_limit", V_FETCH_GO, V_FETCH_GO);
    cycle("wd_decode", 1'b0, 1'b0, 1'b0, V_DECODE);
    cycle("wd_exec", 1'b0, 1'b0, 1'b0, V_EXEC_R);
    cycle("wd_wb", 1'b0, 1'b0, 1'b0, V_ALU_WB);

    opcode = 7'b0100011;
    cycle("rst_st_fetch", 1'b1, 1'b0, 1'b0, V_FETCH_GO);
    cycle("rst_st_decode", 1'b0, 1'b0, 1'b0, V_DECODE);
    cycle("rst_st_addr", 1'b0, 1'b0, 1'b0, V_ADDR);
    cycle("rst_st_wr_wait", 1'b0, 1'b0, 1'b0, V_WR_WAIT);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst_during_memwr", V_NONE, V_NONE);
    reset = 1'b0;
    cycle("rst_release_fetch", 1'b0, 1'b1, 1'b0, V_FETCH_WAIT);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 6));
      f3   = 3'($urandom_range(0, 7));
      case (kind)
        0:       op = 7'b0110011;
        1:       op = 7'b0010011;
        2:       op = 7'b0110111;
        3:       op = 7'b0000011;
        4:       op = 7'b0100011;
        5: begin op = 7'b1100011; f3 = 3'b000; end
        default: begin op = 7'b1100011; f3 = 3'b001; end
      endcase
      runInstr("rand", op, f3, 1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
